// File: rtl/dmux_pkg.sv
// Shared constants for the 8-way 16-bit write distributor.
// Lane count and select width are fixed together.
package dmux_pkg;
  localparam int WIDTH = 16;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/lane_reg.sv
// One-entry holding register for a single output lane.
// A load wins over a same-cycle drain, so the lane stays valid.
module lane_reg
  import dmux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rdy,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end else if (vld && rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux8way16_dist.sv
// Steers a valid/ready word stream into 8 one-entry lanes,
// addressed by sel or by a strict round-robin pointer.
module dmux8way16_dist
  import dmux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [SEL_W-1:0]       rr_ptr
);

  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_tgt;
  logic             w_acc;
  logic [LANES-1:0] w_ld;

  assign w_tgt = (mode == MODE_RR) ? r_rr_ptr : sel;

  // in_ready depends only on lane state, never on in_valid
  assign in_ready = rst_n &
    (~out_valid[w_tgt] | out_ready[w_tgt]);

  assign w_acc = in_valid & in_ready;

  always_comb begin
    w_ld        = '0;
    w_ld[w_tgt] = w_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_acc && mode == MODE_RR) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  assign rr_ptr = r_rr_ptr;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_reg u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (w_ld[g]),
      .d     (in_data),
      .rdy   (out_ready[g]),
      .q     (out_data[g*WIDTH +: WIDTH]),
      .vld   (out_valid[g])
    );
  end

endmodule

// File: tb/tb_dmux8way16_dist.sv
// Randomized and directed checks of the 8-lane distributor
// against a lane-array reference model.
module tb_dmux8way16_dist;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   sel = '0;
  logic         mode = 1'b0;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready = '0;
  logic [2:0]   rr_ptr;

  int total = 0;
  int bad = 0;

  logic [15:0] m_dat [8];
  bit          m_vld [8];
  int          m_rr;

  always #5 clk = ~clk;

  dmux8way16_dist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_dat[i] = '0;
      m_vld[i] = 1'b0;
    end
    m_rr = 0;
  endfunction

  function automatic logic [7:0] model_vmask();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic check_state(string nm);
    total++;
    if (out_valid !== model_vmask()) begin
      bad++;
      $display("FAIL %s out_valid got=%h exp=%h",
               nm, out_valid, model_vmask());
    end
    total++;
    if (rr_ptr !== m_rr[2:0]) begin
      bad++;
      $display("FAIL %s rr_ptr got=%0d exp=%0d",
               nm, rr_ptr, m_rr);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_data[16*i +: 16] !== m_dat[i]) begin
        bad++;
        $display("FAIL %s lane%0d data got=%h exp=%h",
                 nm, i, out_data[16*i +: 16], m_dat[i]);
      end
    end
  endtask

  task automatic step(string nm, output bit accd);
    int          t;
    bit          exp_rdy;
    logic [15:0] d;
    logic [7:0]  ordy;
    #1;
    t = mode ? m_rr : int'(sel);
    exp_rdy = !m_vld[t] || out_ready[t];
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL %s in_ready got=%b exp=%b",
               nm, in_ready, exp_rdy);
    end
    accd = in_valid && exp_rdy;
    d = in_data;
    ordy = out_ready;
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      if (m_vld[i] && ordy[i]) m_vld[i] = 1'b0;
    if (accd) begin
      m_dat[t] = d;
      m_vld[t] = 1'b1;
      if (mode) m_rr = (m_rr + 1) % 8;
    end
    #1;
    check_state(nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data = 16'hA5A5;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset in_ready got=%b exp=0", in_ready);
    end
    check_state("reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rel in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_addressed();
    bit a;
    mode = 1'b0;
    sel = 3'd5;
    out_ready = '0;
    in_data = 16'hBEEF;
    in_valid = 1'b1;
    step("addr_w1", a);
    total++;
    if (out_valid !== 8'h20 || out_data[95:80] !== 16'hBEEF) begin
      bad++;
      $display("FAIL addr_lane5 got v=%h d=%h exp v=20 d=beef",
               out_valid, out_data[95:80]);
    end
    in_data = 16'hCAFE;
    step("addr_w2", a);
    total++;
    if (a) begin
      bad++;
      $display("FAIL addr_block got acc=1 exp acc=0");
    end
    in_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    bit a;
    do_reset();
    mode = 1'b1;
    out_ready = 8'hFF;
    in_valid = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      in_data = 16'(w);
      step("rr", a);
    end
    in_valid = 1'b0;
    total++;
    if (rr_ptr !== 3'd1 || out_data[15:0] !== 16'h0009) begin
      bad++;
      $display("FAIL rr_end got ptr=%0d l0=%h exp ptr=1 l0=0009",
               rr_ptr, out_data[15:0]);
    end
  endtask

  task automatic test_backpressure();
    bit a;
    int n;
    do_reset();
    mode = 1'b1;
    out_ready = '0;
    in_valid = 1'b1;
    n = 1;
    for (int k = 0; k < 10; k++) begin
      in_data = 16'(n);
      step("bp", a);
      if (a) n++;
    end
    #1;
    total++;
    if (n != 9 || in_ready !== 1'b0 || rr_ptr !== 3'd0) begin
      bad++;
      $display("FAIL bp_full got acc=%0d rdy=%b ptr=%0d exp 8 0 0",
               n - 1, in_ready, rr_ptr);
    end
    out_ready = 8'h01;
    in_data = 16'(n);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release in_ready got=%b exp=1", in_ready);
    end
    step("bp_rel", a);
    total++;
    if (out_data[15:0] !== 16'h0009 || !out_valid[0]) begin
      bad++;
      $display("FAIL bp_word9 got l0=%h v=%b exp 0009 1",
               out_data[15:0], out_valid[0]);
    end
    in_valid = 1'b0;
    out_ready = 8'hFF;
    step("bp_drain", a);
  endtask

  task automatic test_replace();
    bit a;
    do_reset();
    mode = 1'b0;
    sel = 3'd3;
    out_ready = '0;
    in_valid = 1'b1;
    in_data = 16'h1111;
    step("rep_ld", a);
    in_data = 16'h2222;
    out_ready = 8'h08;
    #1;
    total++;
    if (out_data[63:48] !== 16'h1111 || !out_valid[3]) begin
      bad++;
      $display("FAIL rep_old got %h v=%b exp 1111 1",
               out_data[63:48], out_valid[3]);
    end
    step("rep_swap", a);
    total++;
    if (out_data[63:48] !== 16'h2222 || out_valid[3] !== 1'b1) begin
      bad++;
      $display("FAIL rep_new got %h v=%b exp 2222 1",
               out_data[63:48], out_valid[3]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit a;
    do_reset();
    mode = 1'b1;
    out_ready = '0;
    in_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      in_data = 16'h4000 + 16'(w);
      step("ar_fill", a);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 8'h00 || rr_ptr !== 3'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got v=%h ptr=%0d rdy=%b exp 00 0 0",
               out_valid, rr_ptr, in_ready);
    end
    check_state("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit a;
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      sel = 3'($urandom);
      mode = 1'($urandom);
      out_ready = 8'($urandom) & 8'($urandom);
      step("rand", a);
    end
    in_valid = 1'b0;
    out_ready = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addressed();
    test_round_robin();
    test_backpressure();
    test_replace();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
